// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes / InvSubBytes over a 128-bit state.
// LANES combined S-box lanes are shared across STEPS cycles, substituting in place.
module sub_bytes_iter #(
    parameter int unsigned BYTE     = 8,
    parameter int unsigned WORD     = 32,
    parameter int unsigned SENTENCE = 128,
    parameter int unsigned LANES    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [SENTENCE-1:0] in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SENTENCE-1:0] out,
    output logic                busy
);

    localparam int unsigned STEPS  = (WORD / BYTE) * (SENTENCE / WORD) / LANES;
    localparam int unsigned STEP_W = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              st;
    logic [STEP_W-1:0]   step;
    logic [SENTENCE-1:0] state_q;
    logic [SENTENCE-1:0] state_nxt;
    logic                mode_q;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int unsigned i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] s;
        for (int unsigned i = 0; i < 8; i++) begin
            s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8];
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        logic [7:0] b;
        for (int unsigned i = 0; i < 8; i++) begin
            b[i] = s[(i + 2) % 8] ^ s[(i + 5) % 8] ^ s[(i + 7) % 8];
        end
        return b ^ 8'h05;
    endfunction

    // One field inversion per lane serves both directions; the affine step moves sides.
    function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic inv);
        logic [7:0] g;
        g = ginv(inv ? inv_affine(x) : x);
        return inv ? g : affine(g);
    endfunction

    always_comb begin
        state_nxt = state_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            state_nxt[(32'(step) * LANES + l) * BYTE +: BYTE] =
                sbox_lane(state_q[(32'(step) * LANES + l) * BYTE +: BYTE], mode_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            step      <= '0;
            state_q   <= '0;
            mode_q    <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        st       <= RUN;
                        state_q  <= in;
                        mode_q   <= mode;
                        step     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    state_q <= state_nxt;
                    if (step == STEP_W'(STEPS - 1)) begin
                        st        <= DONE;
                        step      <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    st        <= IDLE;
                    step      <= '0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out = state_q;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: S-box tables built from GF(2^8) log/antilog
// arithmetic, directed vectors, exhaustive byte sweep, randomized blocks and a LANES sweep.
module tb_sub_bytes_iter;

    localparam int unsigned STEPS = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [127:0] din = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] dout;
    logic         busy;

    always #5 clk = ~clk;

    sub_bytes_iter #(.BYTE(8), .WORD(32), .SENTENCE(128), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in(din), .out_valid(out_valid), .out_ready(out_ready),
        .out(dout), .busy(busy)
    );

    logic [4:0]   sw_iv = '0;
    logic [4:0]   sw_ir;
    logic [4:0]   sw_ov;
    logic [4:0]   sw_busy;
    logic [127:0] sw_out [5];
    logic [127:0] sw_in = '0;
    logic         sw_mode = 1'b0;
    logic         sw_or = 1'b1;

    for (genvar g = 0; g < 5; g++) begin : g_sw
        sub_bytes_iter #(.BYTE(8), .WORD(32), .SENTENCE(128), .LANES(1 << g)) u (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_iv[g]), .in_ready(sw_ir[g]),
            .mode(sw_mode), .in(sw_in), .out_valid(sw_ov[g]), .out_ready(sw_or),
            .out(sw_out[g]), .busy(sw_busy[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;
    int xfers = 0;
    int exp_xfers = 0;

    logic [7:0] sbox_f [256];
    logic [7:0] sbox_i [256];

    always @(posedge clk) if (rst_n && out_valid && out_ready) xfers++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic build_tables;
        logic [7:0] gexp [256];
        int         glog [256];
        logic [7:0] x;
        logic [7:0] b;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x ^ xtime(x);
        end
        for (int a = 0; a < 256; a++) begin
            b = (a == 0) ? 8'h00 : gexp[(255 - glog[a]) % 255];
            sbox_f[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) sbox_i[sbox_f[a]] = 8'(a);
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] blk, input logic md);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = md ? sbox_i[blk[8*k +: 8]] : sbox_f[blk[8*k +: 8]];
        return r;
    endfunction

    task automatic run_block(input logic [127:0] blk, input logic md, input int hold,
                             input bit scramble, output logic [127:0] res);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin tick; t++; end
        check("ready_before_accept", in_ready, 1);
        din = blk; mode = md; in_valid = 1'b1; out_ready = (hold == 0);
        tick;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 200) begin
            check("run_in_ready", in_ready, 0);
            check("run_busy", busy, 1);
            if (scramble) begin
                in_valid = 1'($urandom); mode = 1'($urandom);
                din = {$urandom, $urandom, $urandom, $urandom};
            end
            tick; t++;
        end
        check("latency", t, STEPS);
        res = dout;
        check("result", res, ref_sub(blk, md));
        check("done_busy", busy, 0);
        for (int i = 0; i < hold; i++) begin
            if (scramble) begin
                in_valid = 1'($urandom); mode = 1'($urandom);
                din = {$urandom, $urandom, $urandom, $urandom};
            end
            tick;
            check("hold_valid", out_valid, 1);
            check("hold_out", dout, res);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        exp_xfers++;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] r1, r2, blk;
        int t;
        build_tables();

        // Reset with in_valid held high: reset must win.
        in_valid = 1'b1;
        tick; tick;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out", dout, '0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // First accept lands on the first edge with rst_n high.
        run_block(128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 0, 1'b0, r1);
        check("fips_fwd", r1, 128'hd42711aee0bf98f1b8b45de51e415230);
        run_block(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 0, 1'b0, r1);
        check("fips_inv", r1, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        run_block({16{8'h63}}, 1'b1, 0, 1'b0, r1);
        check("inv_63", r1, '0);

        // Long backpressure with input churn during RUN and DONE.
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 10, 1'b1, r1);

        for (int v = 0; v < 256; v += 16) begin
            for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(v + k);
            run_block(blk, 1'b0, 0, 1'b0, r1);
            run_block(r1, 1'b1, 0, 1'b0, r2);
            check("roundtrip", r2, blk);
        end

        for (int n = 0; n < 24; n++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r1);
        end

        // Abort mid-run at step 2.
        din = {$urandom, $urandom, $urandom, $urandom}; mode = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_out", dout, '0);
        tick; tick;
        check("abort_no_output", out_valid, 0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, 1'b0, r1);

        check("xfer_count", xfers, exp_xfers);

        for (int g = 0; g < 5; g++) begin
            sw_iv[g] = 1'b1;
            tick;
            sw_iv[g] = 1'b0;
            t = 0;
            while (!sw_ov[g] && t < 100) begin tick; t++; end
            check("sweep_latency", t, 16 >> g);
            check("sweep_out", sw_out[g], {16{8'h63}});
            tick;
            check("sweep_release", sw_ov[g], 0);
            check("sweep_ready", sw_ir[g], 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
SUB_BYTES_ITER -- requirements
Module: sub_bytes_iter

Interface
REQ-001 Parameter BYTE, default 8, byte width in bits; only 8 is supported.
REQ-002 Parameter WORD, default 32, word width in bits; informational, equals 4*BYTE.
REQ-003 Parameter SENTENCE, default 128, state width in bits; equals 16*BYTE.
REQ-004 Parameter LANES, default 4, number of S-box lanes (bytes substituted per cycle); legal values are 1, 2, 4, 8 and 16.
REQ-005 Derived constant STEPS = SENTENCE/(BYTE*LANES), the number of cycles per block.
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset, synchronous and active-low.
REQ-008 in_valid  input  1  the input block and mode are valid.
REQ-009 in_ready  output  1  the block can accept a new input.
REQ-010 mode  input  1  0 = forward SubBytes, 1 = InvSubBytes; sampled with in.
REQ-011 in  input  SENTENCE  AES state; byte k = in[8k+7:8k].
REQ-012 out_valid  output  1  out holds a completed result.
REQ-013 out_ready  input  1  the consumer accepts out.
REQ-014 out  output  SENTENCE  substituted state, with the same byte positions as in.
REQ-015 busy  output  1  high while a block is being substituted.

Function
REQ-016 Each output byte SHALL be the FIPS-197 S-box value of the corresponding input byte (mode=0) or the inverse S-box value (mode=1); there is no mixing between bytes.
REQ-017 FSM states:
- IDLE: in_ready=1, busy=0, out_valid=0.
- RUN: in_ready=0, busy=1, out_valid=0.
- DONE: in_ready=0, busy=0, out_valid=1.
REQ-018 IDLE->RUN on in_valid&&in_ready; in and mode are latched in that cycle and the step counter clears to 0.
REQ-019 In RUN, each cycle substitutes bytes [step*LANES .. step*LANES+LANES-1] in place in the state register, lowest bytes first, then increments step.
REQ-020 RUN->DONE on the cycle that processes step STEPS-1; an accept at edge T gives out_valid=1 after edge T+STEPS.
REQ-021 DONE->IDLE on out_valid&&out_ready; out and out_valid SHALL hold stable while out_ready=0.
REQ-022 With LANES=16 (STEPS=1), an accept at edge T SHALL give out_valid=1 after edge T+1.
REQ-023 in_valid is ignored outside IDLE; no input is queued and no data is corrupted. Changes to mode or in after acceptance have no effect.
REQ-024 A new accept is possible at the earliest one cycle after the DONE handshake, so throughput is one block per STEPS+2 cycles.
REQ-025 The step counter SHALL be ceil(log2(STEPS))+1 bits wide and SHALL never exceed STEPS-1 in RUN.
REQ-026 out SHALL equal the state register; its value in IDLE and RUN is don't-care, but it SHALL be deterministic.
REQ-027 Exactly LANES forward and LANES inverse S-box instances (or LANES combined instances) SHALL be used, shared across steps.

Reset
REQ-028 When rst_n=0 at a clock edge:
- FSM goes to IDLE, step counter to 0, state register to 0, latched mode to 0.
- Resulting outputs: in_ready=1, out_valid=0, busy=0, out=0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the block with no output handshake; reset takes priority over in_valid in the same cycle.
REQ-030 The first accept is possible on the first edge with rst_n=1.

Verification
REQ-031 LANES=4, mode=0, in=0x193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out=0xd42711aee0bf98f1b8b45de51e415230 with out_valid rising 4 cycles after the accept.
REQ-032 mode=1, in=0xd42711aee0bf98f1b8b45de51e415230 -> out=0x193de3bea0f4e22b9ac68d2ae9f84808; all-0x63 input -> all-0x00 output.
REQ-033 Sweep LANES over 1, 2, 4, 8, 16 with in=0 and mode=0 -> out=all-0x63, with latency STEPS = 16, 8, 4, 2, 1 respectively.
REQ-034 Hold out_ready=0 for 10 cycles in DONE, and toggle in_valid, mode and in during RUN -> out stable, in_ready=0 throughout, exactly one output transfer.
REQ-035 Pulse rst_n=0 at step 2 of a LANES=4 run -> next cycle in_ready=1, out_valid=0, out=0; a following block completes correctly.
REQ-036 Exhaustive check, mode=0 then mode=1, with byte k set to values v..v+15 for v stepping over 0..255 -> every byte matches the reference S-box/inverse table; forward followed by inverse returns the original input.
